// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: instruction and data memory for the instruction_set_model
// CPU bus, plus the host-side program loader, run control and halt-time dump.
// Words use big-endian bit numbering: bit 0 is the MSB and the opcode is [0:3].
module cpu_mem_responder #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 12,
  parameter int DEPTH    = 4096
) (
  input  logic                clk,
  input  logic                rst,
  // CPU data port
  input  logic [ADDRSIZE-1:0] MEM_ADDR,
  output logic [0:WIDTH-1]    MEM_IN,
  input  logic [0:WIDTH-1]    MEM_OUT,
  input  logic                MEM_CTRL,
  // CPU instruction port
  input  logic [ADDRSIZE-1:0] INS_ADDR,
  output logic [0:WIDTH-1]    INS_MEM,
  output logic                cpu_rst,
  // host program-load stream
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic                ld_sel,
  input  logic [0:WIDTH-1]    ld_data,
  input  logic                ld_last,
  // host read-back port, active only once the CPU has halted
  input  logic                dump_req,
  input  logic [ADDRSIZE-1:0] dump_addr,
  output logic                dump_valid,
  output logic [0:WIDTH-1]    dump_data,
  // status
  output logic [1:0]          state,
  output logic [15:0]         wr_count,
  output logic                halted
);

  typedef enum logic [1:0] {
    S_LOAD = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  localparam logic [3:0]  HLT_OP    = 4'b1001;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  state_t st;

  // Load pointers: next free slot in each memory during LOAD.
  logic [ADDRSIZE-1:0] ipt;
  logic [ADDRSIZE-1:0] dpt;

  logic [0:WIDTH-1] imem [0:DEPTH-1];
  logic [0:WIDTH-1] dmem [0:DEPTH-1];

  logic                ld_fire;
  logic                cpu_wr;
  logic                is_hlt;
  logic                imem_we;
  logic                dmem_we;
  logic [ADDRSIZE-1:0] dmem_waddr;
  logic [0:WIDTH-1]    dmem_wdata;

  // Pointers wrap from the last word back to 0, so an over-long load overwrites.
  function automatic logic [ADDRSIZE-1:0] ptr_next(input logic [ADDRSIZE-1:0] p);
    return (p == ADDRSIZE'(DEPTH - 1)) ? '0 : p + ADDRSIZE'(1);
  endfunction

  // Both read paths are combinational and live in every state.
  assign INS_MEM = imem[INS_ADDR];
  assign MEM_IN  = dmem[MEM_ADDR];
  assign state   = st;

  // Decode this cycle's memory write sources; host and CPU writes are state-exclusive.
  always_comb begin
    // NOTE: every signal gets a value before any condition, so no latch can be inferred.
    ld_fire    = 1'b0;
    cpu_wr     = 1'b0;
    is_hlt     = 1'b0;
    imem_we    = 1'b0;
    dmem_we    = 1'b0;
    dmem_waddr = dpt;
    dmem_wdata = ld_data;

    ld_fire = (st == S_LOAD) && ld_valid && ld_ready;
    cpu_wr  = (st == S_RUN) && MEM_CTRL;
    is_hlt  = (st == S_RUN) && (INS_MEM[0:3] == HLT_OP);

    if (cpu_wr) begin
      dmem_waddr = MEM_ADDR;
      dmem_wdata = MEM_OUT;
    end

    // A cycle with rst asserted commits nothing, matching the register reset.
    imem_we = ld_fire && !ld_sel && !rst;
    dmem_we = ((ld_fire && ld_sel) || cpu_wr) && !rst;
  end

  // Instruction memory: written only by the host loader.
  // NOTE: memory arrays carry no reset; their contents deliberately survive rst.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[ipt] <= ld_data;
    end
  end

  // Data memory: host loader in LOAD, CPU stores in RUN.
  always_ff @(posedge clk) begin
    if (dmem_we) begin
      dmem[dmem_waddr] <= dmem_wdata;
    end
  end

  // Control FSM: load sequencing, CPU release/freeze, store counting and dump reads.
  // NOTE: sequential state is assigned with <= only, so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= S_LOAD;
      cpu_rst    <= 1'b1;
      ld_ready   <= 1'b1;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      wr_count   <= '0;
      halted     <= 1'b0;
      ipt        <= '0;
      dpt        <= '0;
    end else begin
      case (st)
        S_LOAD: begin
          if (ld_fire) begin
            if (ld_sel) begin
              dpt <= ptr_next(dpt);
            end else begin
              ipt <= ptr_next(ipt);
            end
            // The final word is still written; the CPU is released on this same edge.
            if (ld_last) begin
              st       <= S_RUN;
              cpu_rst  <= 1'b0;
              ld_ready <= 1'b0;
            end
          end
        end

        S_RUN: begin
          if (cpu_wr && (wr_count != COUNT_MAX)) begin
            wr_count <= wr_count + 16'd1;
          end
          // A store presented alongside HLT is committed by the dmem block regardless.
          if (is_hlt) begin
            st      <= S_HALT;
            cpu_rst <= 1'b1;
            halted  <= 1'b1;
          end
        end

        S_HALT: begin
          // One-cycle read latency; dump_data holds its value between requests.
          dump_valid <= dump_req;
          if (dump_req) begin
            dump_data <= dmem[dump_addr];
          end
        end

        default: begin
          st <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: program load, a small behavioural CPU,
// halt-time dumps through a scoreboard queue, pointer wrap, mid-load reset and
// store-counter saturation.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] MEM_ADDR;
  logic [0:31] MEM_IN;
  logic [0:31] MEM_OUT;
  logic        MEM_CTRL;
  logic [11:0] INS_ADDR;
  logic [0:31] INS_MEM;
  logic        cpu_rst;
  logic        ld_valid;
  logic        ld_ready;
  logic        ld_sel;
  logic [0:31] ld_data;
  logic        ld_last;
  logic        dump_req;
  logic [11:0] dump_addr;
  logic        dump_valid;
  logic [0:31] dump_data;
  logic [1:0]  state;
  logic [15:0] wr_count;
  logic        halted;

  int checks = 0;
  int errors = 0;

  // Expected dump results, pushed when a request is driven.
  logic [31:0] exp_q[$];

  cpu_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_IN     (MEM_IN),
    .MEM_OUT    (MEM_OUT),
    .MEM_CTRL   (MEM_CTRL),
    .INS_ADDR   (INS_ADDR),
    .INS_MEM    (INS_MEM),
    .cpu_rst    (cpu_rst),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_sel     (ld_sel),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .dump_req   (dump_req),
    .dump_addr  (dump_addr),
    .dump_valid (dump_valid),
    .dump_data  (dump_data),
    .state      (state),
    .wr_count   (wr_count),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, settle past the edge, then retire any dump result.
  task automatic tick();
    @(posedge clk);
    #1;
    if (dump_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("dump_spurious_valid", 32'(dump_valid), 32'd0);
      end else begin
        check("dump_data", dump_data, exp_q.pop_front());
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_word(input logic sel, input logic [31:0] data, input logic last);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_data  = data;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Tiny CPU: 2 = LD imm ir[27:12] -> R[ir[3:0]], 3 = STR R[ir[15:12]] -> [ir[11:0]],
  // anything else holds the fetch address. Bounded by max_cycles.
  task automatic run_cpu(input int max_cycles, output int cycles);
    logic [31:0] ir;
    logic [31:0] regs [16];
    int pc;
    pc     = 0;
    cycles = 0;
    for (int r = 0; r < 16; r++) regs[r] = '0;
    while (state != 2'b10 && cycles < max_cycles) begin
      INS_ADDR = 12'(pc);
      MEM_CTRL = 1'b0;
      #1;
      ir = INS_MEM;
      case (ir[31:28])
        4'h2: begin
          regs[ir[3:0]] = {16'h0000, ir[27:12]};
          pc++;
        end
        4'h3: begin
          MEM_ADDR = ir[11:0];
          MEM_OUT  = regs[ir[15:12]];
          MEM_CTRL = 1'b1;
          pc++;
        end
        default: ;
      endcase
      tick();
      cycles++;
    end
    MEM_CTRL = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [31:0] prog [3];
    logic [11:0] dump_list [4];
    logic [31:0] dump_exp  [4];
    logic [31:0] w [5];

    prog[0] = 32'h2000_5001;
    prog[1] = 32'h3000_1010;
    prog[2] = 32'h9000_0000;

    rst = 1'b1; MEM_ADDR = '0; MEM_OUT = '0; MEM_CTRL = 1'b0; INS_ADDR = '0;
    ld_valid = 1'b0; ld_sel = 1'b0; ld_data = '0; ld_last = 1'b0;
    dump_req = 1'b0; dump_addr = '0;

    // ---- reset values
    do_reset();
    check("rst_state",      32'(state),      32'd0);
    check("rst_cpu_rst",    32'(cpu_rst),    32'd1);
    check("rst_ld_ready",   32'(ld_ready),   32'd1);
    check("rst_dump_valid", 32'(dump_valid), 32'd0);
    check("rst_dump_data",  dump_data,       32'd0);
    check("rst_wr_count",   32'(wr_count),   32'd0);
    check("rst_halted",     32'(halted),     32'd0);

    // ---- program load; ld_last without ld_valid must be ignored
    load_word(1'b0, prog[0], 1'b0);
    load_word(1'b0, prog[1], 1'b0);
    ld_last = 1'b1;
    tick();
    ld_last = 1'b0;
    check("last_no_valid_state", 32'(state),   32'd0);
    check("last_no_valid_cpu",   32'(cpu_rst), 32'd1);
    load_word(1'b0, prog[2], 1'b1);
    check("release_ld_ready", 32'(ld_ready), 32'd0);
    check("release_state",    32'(state),    32'd1);
    check("release_cpu_rst",  32'(cpu_rst),  32'd0);

    // ---- CPU runs LD / STR / HLT
    run_cpu(20, cyc);
    check("halt_within_4",  32'(cyc <= 4),   32'd1);
    check("halt_state",     32'(state),      32'd2);
    check("halt_cpu_rst",   32'(cpu_rst),    32'd1);
    check("halt_halted",    32'(halted),     32'd1);
    check("halt_wr_count",  32'(wr_count),   32'd1);
    check("halt_ld_ready",  32'(ld_ready),   32'd0);
    MEM_ADDR = 12'h010;
    #1;
    check("store_result", MEM_IN, 32'h0000_0005);

    // CPU stores are ignored once halted
    MEM_OUT  = 32'hDEAD_BEEF;
    MEM_CTRL = 1'b1;
    tick();
    MEM_CTRL = 1'b0;
    check("halt_ignores_store", MEM_IN, 32'h0000_0005);
    check("halt_count_frozen",  32'(wr_count), 32'd1);

    for (int i = 0; i < 3; i++) begin
      INS_ADDR = 12'(i);
      #1;
      check($sformatf("imem_%0d", i), INS_MEM, prog[i]);
    end
    INS_ADDR = '0;

    // ---- single dump, then idle
    dump_addr = 12'h010;
    dump_req  = 1'b1;
    exp_q.push_back(32'h0000_0005);
    tick();
    dump_req = 1'b0;
    tick();
    check("dump_idle_valid",  32'(dump_valid), 32'd0);
    check("dump_idle_hold",   dump_data,       32'h0000_0005);
    check("dump_outstanding", 32'(exp_q.size()), 32'd0);

    // ---- 4097 data words: dmem pointer wraps and overwrites word 0
    do_reset();
    INS_ADDR = '0;
    check("rst2_wr_count", 32'(wr_count), 32'd0);
    check("rst2_halted",   32'(halted),   32'd0);
    for (int i = 0; i <= 4096; i++) begin
      load_word(1'b1, 32'(i), 1'(i == 4096));
    end
    check("wrap_state", 32'(state), 32'd1);
    MEM_ADDR = 12'h000;
    #1;
    check("wrap_dmem0", MEM_IN, 32'd4096);
    MEM_ADDR = 12'h001;
    #1;
    check("wrap_dmem1", MEM_IN, 32'd1);

    // program in imem survived reset; run it again, then dump back-to-back
    run_cpu(20, cyc);
    check("rerun_halt", 32'(state), 32'd2);
    dump_list[0] = 12'h000; dump_exp[0] = 32'd4096;
    dump_list[1] = 12'h001; dump_exp[1] = 32'd1;
    dump_list[2] = 12'hFFF; dump_exp[2] = 32'd4095;
    dump_list[3] = 12'h010; dump_exp[3] = 32'd5;
    for (int i = 0; i < 4; i++) begin
      dump_addr = dump_list[i];
      dump_req  = 1'b1;
      exp_q.push_back(dump_exp[i]);
      tick();
    end
    dump_req = 1'b0;
    tick();
    check("b2b_idle_valid",  32'(dump_valid),    32'd0);
    check("b2b_outstanding", 32'(exp_q.size()), 32'd0);

    // ---- reset in the middle of a load
    do_reset();
    INS_ADDR = '0;
    load_word(1'b0, 32'hA1A1_A1A1, 1'b0);
    load_word(1'b0, 32'hB2B2_B2B2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_state",      32'(state),      32'd0);
    check("midrst_cpu_rst",    32'(cpu_rst),    32'd1);
    check("midrst_ld_ready",   32'(ld_ready),   32'd1);
    check("midrst_wr_count",   32'(wr_count),   32'd0);
    check("midrst_dump_valid", 32'(dump_valid), 32'd0);
    INS_ADDR = 12'h001;
    #1;
    check("midrst_no_rollback", INS_MEM, 32'hB2B2_B2B2);

    for (int i = 0; i < 4; i++) w[i] = 32'h1111_0000 + 32'(i);
    w[4] = 32'h9000_0004;
    INS_ADDR = '0;
    for (int i = 0; i < 4; i++) load_word(1'b0, w[i], 1'b0);
    for (int i = 0; i < 4; i++) begin
      INS_ADDR = 12'(i);
      #1;
      check($sformatf("reload_imem_%0d", i), INS_MEM, w[i]);
    end
    INS_ADDR = '0;
    load_word(1'b0, w[4], 1'b1);
    check("reload_state", 32'(state), 32'd1);

    // ---- dump_req ignored in RUN
    for (int i = 0; i < 4; i++) begin
      dump_addr = 12'(i);
      dump_req  = 1'(i % 2 == 0);
      tick();
      check("run_dump_valid", 32'(dump_valid), 32'd0);
    end
    dump_req = 1'b0;

    // ---- CPU store visible next cycle, then counter saturation
    MEM_ADDR = 12'h020;
    MEM_OUT  = 32'h1234_5678;
    MEM_CTRL = 1'b1;
    tick();
    MEM_CTRL = 1'b0;
    check("run_store_visible", MEM_IN, 32'h1234_5678);
    check("run_count_1",       32'(wr_count), 32'd1);
    MEM_ADDR = 12'h021;
    MEM_CTRL = 1'b1;
    for (int i = 0; i < 65533; i++) begin
      MEM_OUT = 32'(i);
      tick();
    end
    check("count_below_max", 32'(wr_count), 32'h0000_FFFE);
    for (int i = 0; i < 4467; i++) tick();
    MEM_CTRL = 1'b0;
    check("count_saturated", 32'(wr_count), 32'h0000_FFFF);
    check("sat_still_run",   32'(state),    32'd1);

    // ---- store on the HLT edge is still committed
    MEM_ADDR = 12'h030;
    MEM_OUT  = 32'hCAFE_F00D;
    MEM_CTRL = 1'b1;
    INS_ADDR = 12'h004;
    tick();
    MEM_CTRL = 1'b0;
    check("hlt_edge_state",   32'(state),   32'd2);
    check("hlt_edge_cpu_rst", 32'(cpu_rst), 32'd1);
    check("hlt_edge_store",   MEM_IN,       32'hCAFE_F00D);
    check("hlt_edge_count",   32'(wr_count), 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the instruction_set_model CPU bus: serves instruction fetches on INS_ADDR/INS_MEM and data loads/stores on MEM_ADDR/MEM_IN/MEM_OUT/MEM_CTRL.
- Owns the program-load sequence: a host streams instruction and data words in through a valid/ready port while the CPU is held in reset. It then releases the CPU, detects HLT, freezes the CPU, and lets the host read back data memory.

Parameters:
- WIDTH, 32, data word width
- ADDRSIZE, 12, address width
- DEPTH, 4096, words per memory (2^ADDRSIZE)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- MEM_ADDR  in  ADDRSIZE  CPU data address
- MEM_IN  out  [0:WIDTH-1]  read data to CPU
- MEM_OUT  in  [0:WIDTH-1]  write data from CPU
- MEM_CTRL  in  1  0 = read, 1 = write
- INS_ADDR  in  ADDRSIZE  CPU fetch address
- INS_MEM  out  [0:WIDTH-1]  instruction word to CPU
- cpu_rst  out  1  drives the CPU's rst input
- ld_valid  in  1  host load word valid
- ld_ready  out  1  responder accepts load word
- ld_sel  in  1  0 = instruction memory, 1 = data memory
- ld_data  in  [0:WIDTH-1]  load word
- ld_last  in  1  final load word
- dump_req  in  1  host read request (HALT only)
- dump_addr  in  ADDRSIZE  host read address
- dump_valid  out  1  dump_data valid
- dump_data  out  [0:WIDTH-1]  host read data
- state  out  2  00 = LOAD, 01 = RUN, 10 = HALT
- wr_count  out  16  CPU data writes committed, saturating
- halted  out  1  state == HALT

Behaviour:
- Storage: imem and dmem, each DEPTH x WIDTH. Neither array is cleared by rst; contents persist across reset.
- Bit order: bit 0 is the MSB and words are stored as presented. Opcode is word bits [0:3], which the CPU sees as ir[31:28].
- Reset values:
  - state = LOAD
  - cpu_rst = 1, ld_ready = 1
  - dump_valid = 0, dump_data = 0
  - wr_count = 0, halted = 0
  - ipt = dpt = 0 (internal load pointers)
- Read paths:
  - INS_MEM = imem[INS_ADDR], combinational.
  - MEM_IN = dmem[MEM_ADDR], combinational.
  - Both are driven in every state.
- LOAD:
  - ld_ready = 1.
  - On a cycle with ld_valid & ld_ready:
    - ld_sel = 0: write ld_data to imem[ipt], ipt += 1.
    - ld_sel = 1: write ld_data to dmem[dpt], dpt += 1.
    - Pointers wrap DEPTH-1 -> 0; a wrapped write overwrites.
  - If the accepted word has ld_last = 1, the word is written and the next state is RUN.
  - ld_last without ld_valid is ignored.
- RUN:
  - ld_ready = 0, cpu_rst = 0. cpu_rst is registered and falls on the same edge state becomes RUN.
  - At posedge with MEM_CTRL = 1: dmem[MEM_ADDR] <= MEM_OUT and wr_count += 1, saturating at 16'hFFFF. The written value is visible on MEM_IN from the next cycle.
  - At posedge with INS_MEM[0:3] == 4'b1001 (HLT): next state is HALT and cpu_rst returns to 1.
  - A store presented on the same edge as HLT detection is still committed.
- HALT:
  - cpu_rst = 1, halted = 1, ld_ready = 0.
  - MEM_CTRL is ignored.
  - dump_req at posedge: dump_valid = 1 and dump_data = dmem[dump_addr] in the next cycle (latency 1). Back-to-back requests give one result per cycle.
  - No dump_req: dump_valid = 0 and dump_data holds its last value.
  - HALT is left only by rst.
- dump_req in LOAD or RUN is ignored; dump_valid stays 0.
- rst mid-LOAD or mid-RUN:
  - All registers return to their reset values and state becomes LOAD.
  - The memories keep their contents.
  - A partially accepted load is not rolled back.
- Host ld writes and CPU writes never coexist, because they occur in disjoint states.

Test Plan:
- Reset, then load imem words 0x2000_5001 (LD imm 5 -> R1), 0x3000_1010 (STR R1 -> [0x010]), 0x9000_0000 (HLT) with ld_last on the third -> ld_ready drops, state = 01, cpu_rst falls on that edge, imem[0..2] match.
- Continue with the CPU attached -> dmem[0x010] = 0x0000_0005, wr_count = 1, state = 10 within 4 cycles of release, cpu_rst = 1.
- In HALT, dump_req with dump_addr 0x010 for one cycle -> next cycle dump_valid = 1, dump_data = 0x0000_0005; the following cycle dump_valid = 0.
- Load 4097 data words 0..4096 (ld_sel = 1) -> dmem[0] = 4096 (pointer wrapped), dmem[1] = 1.
- Assert rst mid-load after 2 of 5 words -> state = LOAD, ipt = 0, cpu_rst = 1, wr_count = 0; a new load overwrites from address 0.
- Drive MEM_CTRL = 1 for 70000 cycles in RUN -> wr_count saturates at 0xFFFF; toggling dump_req in RUN -> dump_valid stays 0.
